// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I/D cache to memory arbiter: FSM states, grant
// history encoding and the registered memory request.
package cache_types;

   localparam int unsigned LINE_W = 256;

   typedef enum logic [1:0] {
      IDLE,
      I_BUSY,
      D_BUSY,
      DRAIN
   } arb_state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_t;

   typedef struct packed {
      logic [31:0]       addr;
      logic              write;
      logic [LINE_W-1:0] wdata;
   } arb_req_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto a single memory
// port with one outstanding transaction; I-side can be cancelled by flush.
module cache_mem_arbiter #(
   parameter int unsigned LINE_W = cache_types::LINE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic [31:0]       d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   input  logic              flush,
   output logic [31:0]       mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);
   import cache_types::*;

   arb_state_t r_state;
   arb_state_t w_next_state;
   grant_t     r_last_grant;
   grant_t     w_next_grant;
   arb_req_t   r_req;
   arb_req_t   w_next_req;
   logic       w_i_pend;
   logic       w_d_pend;
   logic       w_grant_d;
   logic       w_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= GNT_I;
         r_req        <= '0;
      end else begin
         r_state      <= w_next_state;
         r_last_grant <= w_next_grant;
         r_req        <= w_next_req;
      end
   end

   // A flush in IDLE masks the I request for that cycle only.
   assign w_i_pend  = i_read & ~flush;
   assign w_d_pend  = d_read | d_write;
   assign w_grant_d = w_d_pend & (~w_i_pend | (r_last_grant == GNT_I));

   always_comb begin
      w_next_state = r_state;
      w_next_grant = r_last_grant;
      w_next_req   = r_req;
      i_resp       = 1'b0;
      d_resp       = 1'b0;
      i_rdata      = '0;
      d_rdata      = '0;
      case (r_state)
         IDLE: begin
            if (w_grant_d) begin
               w_next_req.addr  = d_addr;
               w_next_req.write = d_write;
               w_next_req.wdata = d_wdata;
               w_next_state     = D_BUSY;
            end else if (w_i_pend) begin
               w_next_req.addr  = i_addr;
               w_next_req.write = 1'b0;
               w_next_req.wdata = '0;
               w_next_state     = I_BUSY;
            end
         end
         I_BUSY: begin
            if (mem_resp) begin
               i_resp       = ~flush;
               i_rdata      = flush ? '0 : mem_rdata;
               w_next_grant = GNT_I;
               w_next_state = IDLE;
            end else if (flush) begin
               w_next_state = DRAIN;
            end
         end
         D_BUSY: begin
            if (mem_resp) begin
               d_resp       = 1'b1;
               d_rdata      = mem_rdata;
               w_next_grant = GNT_D;
               w_next_state = IDLE;
            end
         end
         DRAIN: begin
            // Cancelled fill still owns the memory port until it completes.
            if (mem_resp) begin
               w_next_grant = GNT_I;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   assign w_busy    = (r_state != IDLE);
   assign mem_read  = w_busy & ~r_req.write;
   assign mem_write = w_busy & r_req.write;
   assign mem_addr  = r_req.addr;
   assign mem_wdata = r_req.wdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter with a latency-programmable memory model.
module tb_cache_mem_arbiter;
   localparam int unsigned LINE_W = cache_types::LINE_W;

   typedef struct {
      bit                is_d;
      logic [LINE_W-1:0] data;
   } exp_t;

   typedef struct {
      logic [31:0]       addr;
      logic [LINE_W-1:0] data;
   } wr_t;

   logic              clk;
   logic              rst_n;
   logic [31:0]       i_addr;
   logic              i_read;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic [31:0]       d_addr;
   logic              d_read;
   logic              d_write;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              flush;
   logic [31:0]       mem_addr;
   logic              mem_read;
   logic              mem_write;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];
   wr_t  wr_log[$];

   int mem_lat = 1;
   bit stray   = 0;

   logic              tr_mr[64];
   logic              tr_mw[64];
   logic              tr_ir[64];
   logic              tr_dr[64];
   logic [31:0]       tr_addr[64];
   logic [LINE_W-1:0] tr_wd[64];
   int t = 0;

   cache_mem_arbiter #(.LINE_W(LINE_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp), .flush(flush),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [LINE_W-1:0] line_of(input logic [31:0] a);
      logic [LINE_W-1:0] r;
      for (int unsigned k = 0; k < LINE_W / 32; k++)
         r[k*32 +: 32] = (a ^ 32'hC0DE_0000) + k * 32'h0101_0101;
      return r;
   endfunction

   // Memory model: answers after mem_lat cycles of strobe, checks strobe stability.
   initial begin
      logic [31:0]       m_addr;
      logic              m_wr;
      logic [LINE_W-1:0] m_wd;
      int                cnt;
      cnt       = 0;
      mem_resp  = 1'b0;
      mem_rdata = '0;
      m_addr    = '0;
      m_wr      = 1'b0;
      m_wd      = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            mem_resp = 1'b0; mem_rdata = '0; cnt = 0;
         end else if (stray) begin
            stray = 0; mem_resp = 1'b1; mem_rdata = line_of(32'hDEAD_0000);
         end else if (mem_resp) begin
            mem_resp = 1'b0; mem_rdata = '0; cnt = 0;
         end else if (mem_read || mem_write) begin
            cnt++;
            if (cnt == 1) begin
               m_addr = mem_addr; m_wr = mem_write; m_wd = mem_wdata;
            end else begin
               checks++;
               if (mem_addr !== m_addr || mem_write !== m_wr || mem_wdata !== m_wd) begin
                  errors++;
                  $display("FAIL strobe_stable: addr %h wr %b expected addr %h wr %b", mem_addr, mem_write, m_addr, m_wr);
               end
            end
            if (cnt == mem_lat + 1) begin
               mem_resp  = 1'b1;
               mem_rdata = line_of(m_addr);
               if (m_wr) wr_log.push_back('{addr: m_addr, data: m_wd});
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Response monitor: pops the scoreboard on every completion pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            checks++;
            if ((mem_read & mem_write) || (i_resp & d_resp)) begin
               errors++;
               $display("FAIL exclusive: mem_read %b mem_write %b i_resp %b d_resp %b", mem_read, mem_write, i_resp, d_resp);
            end
            checks++;
            if ((!i_resp && i_rdata !== '0) || (!d_resp && d_rdata !== '0)) begin
               errors++;
               $display("FAIL rdata_zero: i_rdata %h d_rdata %h required 0", i_rdata, d_rdata);
            end
            if (i_resp || d_resp) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_resp: i_resp %b d_resp %b with empty scoreboard", i_resp, d_resp);
               end else begin
                  e = exp_q.pop_front();
                  if (d_resp !== e.is_d || (e.is_d ? d_rdata : i_rdata) !== e.data) begin
                     errors++;
                     $display("FAIL resp_order: side_d %b data %h expected side_d %b data %h",
                              d_resp, e.is_d ? d_rdata : i_rdata, e.is_d, e.data);
                  end
               end
            end
         end
      end
   end

   task automatic run_trace(input int n);
      logic li, ld;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (t < 64) begin
            tr_mr[t] = mem_read;  tr_mw[t] = mem_write;
            tr_ir[t] = i_resp;    tr_dr[t] = d_resp;
            tr_addr[t] = mem_addr; tr_wd[t] = mem_wdata;
         end
         li = i_resp; ld = d_resp;
         t++;
         @(posedge clk);
         #1;
         if (li) i_read = 1'b0;
         if (ld) begin d_read = 1'b0; d_write = 1'b0; end
      end
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while ((exp_q.size() != 0 || mem_read || mem_write) && n < budget) begin
         run_trace(1);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_timeout: %0d responses still pending after %0d cycles, required 0", name, exp_q.size(), budget);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0;
      d_write = 1'b0; d_wdata = '0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0) begin
         errors++;
         $display("FAIL reset_strobes: %b required 0000", {mem_read, mem_write, i_resp, d_resp});
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_req: mem_addr %h mem_wdata %h required 0", mem_addr, mem_wdata);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_i();
      t = 0; mem_lat = 5;
      i_addr = 32'h0000_1000; i_read = 1'b1;
      exp_q.push_back('{is_d: 1'b0, data: line_of(32'h0000_1000)});
      run_trace(8);
      checks++;
      if (tr_mr[0] !== 1'b0 || tr_mr[1] !== 1'b1) begin
         errors++;
         $display("FAIL i_grant_latency: mem_read c0 %b c1 %b required 0 1", tr_mr[0], tr_mr[1]);
      end
      checks++;
      if (tr_addr[1] !== 32'h0000_1000) begin
         errors++;
         $display("FAIL i_mem_addr: %h required 00001000", tr_addr[1]);
      end
      checks++;
      if (tr_ir[5] !== 1'b0 || tr_ir[6] !== 1'b1) begin
         errors++;
         $display("FAIL i_resp_cycle: c5 %b c6 %b required 0 1", tr_ir[5], tr_ir[6]);
      end
      checks++;
      if (tr_mr[7] !== 1'b0) begin
         errors++;
         $display("FAIL i_strobe_release: mem_read c7 %b required 0", tr_mr[7]);
      end
      wait_done(20, "single_i");
   endtask

   task automatic test_write();
      logic [LINE_W-1:0] pat;
      wr_t w;
      pat = {(LINE_W/8){8'hA5}};
      t = 0; mem_lat = 2;
      d_addr = 32'h0000_2040; d_wdata = pat; d_write = 1'b1;
      exp_q.push_back('{is_d: 1'b1, data: line_of(32'h0000_2040)});
      run_trace(5);
      checks++;
      if (tr_mw[1] !== 1'b1 || tr_mr[1] !== 1'b0 || tr_addr[1] !== 32'h0000_2040 || tr_wd[1] !== pat) begin
         errors++;
         $display("FAIL wr_strobe: mw %b mr %b addr %h wdata %h required 1 0 00002040 %h",
                  tr_mw[1], tr_mr[1], tr_addr[1], tr_wd[1], pat);
      end
      checks++;
      if (tr_dr[3] !== 1'b1) begin
         errors++;
         $display("FAIL wr_resp: d_resp c3 %b required 1", tr_dr[3]);
      end
      wait_done(20, "write");
      checks++;
      if (wr_log.size() != 1) begin
         errors++;
         $display("FAIL wr_log_count: %0d required 1", wr_log.size());
      end else begin
         w = wr_log.pop_front();
         if (w.addr !== 32'h0000_2040 || w.data !== pat) begin
            errors++;
            $display("FAIL wr_log_data: addr %h data %h required 00002040 %h", w.addr, w.data, pat);
         end
      end
      wr_log.delete();

      pat = {(LINE_W/32){32'h1234_5678}};
      t = 0;
      d_addr = 32'h0000_2080; d_wdata = pat; d_read = 1'b1; d_write = 1'b1;
      exp_q.push_back('{is_d: 1'b1, data: line_of(32'h0000_2080)});
      run_trace(2);
      checks++;
      if (tr_mw[1] !== 1'b1 || tr_mr[1] !== 1'b0) begin
         errors++;
         $display("FAIL rd_wr_as_write: mw %b mr %b required 1 0", tr_mw[1], tr_mr[1]);
      end
      wait_done(20, "rd_wr");
      checks++;
      if (wr_log.size() != 1 || wr_log[0].addr !== 32'h0000_2080 || wr_log[0].data !== pat) begin
         errors++;
         $display("FAIL rd_wr_log: %0d entries, required 1 at 00002080", wr_log.size());
      end
      wr_log.delete();
   endtask

   task automatic test_flush_idle();
      t = 0; mem_lat = 1;
      i_addr = 32'h0000_9000; i_read = 1'b1;
      d_addr = 32'h0000_A000; d_read = 1'b1; flush = 1'b1;
      exp_q.push_back('{is_d: 1'b1, data: line_of(32'h0000_A000)});
      exp_q.push_back('{is_d: 1'b0, data: line_of(32'h0000_9000)});
      run_trace(1);
      flush = 1'b0;
      run_trace(1);
      checks++;
      if (tr_addr[1] !== 32'h0000_A000 || tr_mr[1] !== 1'b1) begin
         errors++;
         $display("FAIL flush_idle_grant: addr %h mr %b required 0000a000 1", tr_addr[1], tr_mr[1]);
      end
      wait_done(30, "flush_idle");
   endtask

   task automatic test_flush_drain();
      bit saw;
      t = 0; mem_lat = 4;
      i_addr = 32'h0000_3000; i_read = 1'b1;
      run_trace(1);
      d_addr = 32'h0000_4000; d_read = 1'b1;
      exp_q.push_back('{is_d: 1'b1, data: line_of(32'h0000_4000)});
      run_trace(1);
      flush = 1'b1; i_read = 1'b0;
      run_trace(1);
      flush = 1'b0;
      run_trace(6);
      flush = 1'b1;
      run_trace(1);
      flush = 1'b0;
      checks++;
      if (tr_mr[3] !== 1'b1 || tr_mr[5] !== 1'b1 || tr_addr[5] !== 32'h0000_3000) begin
         errors++;
         $display("FAIL drain_strobe: c3 %b c5 %b addr %h required 1 1 00003000", tr_mr[3], tr_mr[5], tr_addr[5]);
      end
      saw = 0;
      for (int k = 0; k < 10; k++) if (tr_ir[k] === 1'b1) saw = 1;
      checks++;
      if (saw) begin
         errors++;
         $display("FAIL drain_no_iresp: i_resp 1 seen, required never");
      end
      checks++;
      if (tr_mr[6] !== 1'b0 || tr_mr[7] !== 1'b1 || tr_addr[7] !== 32'h0000_4000) begin
         errors++;
         $display("FAIL drain_then_d: c6 %b c7 %b addr %h required 0 1 00004000", tr_mr[6], tr_mr[7], tr_addr[7]);
      end
      wait_done(30, "flush_drain");
   endtask

   task automatic test_flush_resp();
      t = 0; mem_lat = 3;
      i_addr = 32'h0000_B000; i_read = 1'b1;
      run_trace(4);
      flush = 1'b1; i_read = 1'b0;
      run_trace(1);
      flush = 1'b0;
      run_trace(1);
      checks++;
      if (tr_mr[4] !== 1'b1 || tr_ir[4] !== 1'b0 || tr_mr[5] !== 1'b0) begin
         errors++;
         $display("FAIL flush_with_resp: mr c4 %b i_resp c4 %b mr c5 %b required 1 0 0", tr_mr[4], tr_ir[4], tr_mr[5]);
      end
   endtask

   task automatic test_back_to_back();
      int ni = 0, nd = 0, n = 0;
      logic li, ld;
      do_reset();
      mem_lat = 1;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back('{is_d: 1'b1, data: line_of(32'h0000_8000 + 32'(k) * 32'h20)});
         exp_q.push_back('{is_d: 1'b0, data: line_of(32'h0000_7000 + 32'(k) * 32'h20)});
      end
      i_addr = 32'h0000_7000; d_addr = 32'h0000_8000;
      i_read = 1'b1; d_read = 1'b1;
      while ((ni < 3 || nd < 3) && n < 80) begin
         @(negedge clk);
         li = i_resp; ld = d_resp;
         @(posedge clk);
         #1;
         if (ld) begin
            nd++;
            if (nd < 3) d_addr = d_addr + 32'h20; else d_read = 1'b0;
         end
         if (li) begin
            ni++;
            if (ni < 3) i_addr = i_addr + 32'h20; else i_read = 1'b0;
         end
         n++;
      end
      checks++;
      if (n >= 80 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL tie_alternation: served i %0d d %0d, %0d pending, required 3 3 0", ni, nd, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      t = 0; mem_lat = 10;
      d_addr = 32'h0000_5000; d_read = 1'b1;
      exp_q.push_back('{is_d: 1'b1, data: line_of(32'h0000_5000)});
      run_trace(3);
      checks++;
      if (tr_mr[2] !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: mem_read %b required 1", tr_mr[2]);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0 || mem_addr !== 32'h0 || d_rdata !== '0) begin
         errors++;
         $display("FAIL async_reset: strobes %b addr %h required 0000 00000000",
                  {mem_read, mem_write, i_resp, d_resp}, mem_addr);
      end
      exp_q.delete();
      d_read = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      stray = 1;
      t = 0;
      run_trace(3);
      checks++;
      if (tr_ir[0] !== 1'b0 || tr_dr[0] !== 1'b0 || tr_mr[1] !== 1'b0) begin
         errors++;
         $display("FAIL stray_resp: i_resp %b d_resp %b mr %b required 0 0 0", tr_ir[0], tr_dr[0], tr_mr[1]);
      end
      mem_lat = 1;
      i_addr = 32'h0000_6000; i_read = 1'b1;
      exp_q.push_back('{is_d: 1'b0, data: line_of(32'h0000_6000)});
      wait_done(20, "post_reset");
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_single_i();
      test_write();
      test_flush_idle();
      test_flush_drain();
      test_flush_resp();
      test_back_to_back();
      test_reset_mid();
      run_trace(2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
